io_channel_unit: RTL and testbench

//  Parametrised input/output channel unit for the zero VM on FPGA. Replaces the fixed inline

---
 rtl/io_channel_unit.sv | 192 +++++++++++++++++++
 tb/tb_io_channel_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_channel_unit.sv
// I/O channel unit for the zero VM: NChannels loader-fed input FIFOs, one consumer-drained
// output FIFO, and a single-outstanding request/response port toward the VM core.

module io_fifo #(
    parameter int W  = 12,
    parameter int N  = 16,
    parameter int NB = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [NB-1:0] count,
    output logic          full
);
    localparam int PB = $clog2(N);

    logic [W-1:0]  mem [N];
    logic [PB-1:0] wptr, rptr;

    // Callers only pop when non-empty; push while full is only legal together with a pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= push_data;
    end

    assign head = mem[rptr];
    assign full = (count == NB'(N));
endmodule

module io_channel_unit #(
    parameter int MemoryElementWidth = 12,
    parameter int NIn                = 16,
    parameter int NOut               = 16,
    parameter int NChannels          = 2,
    parameter bit OutOverwrite       = 1'b0,
    parameter int CB = (NChannels > 1) ? $clog2(NChannels) : 1,
    parameter int NB = $clog2(NIn + 1),
    parameter int OB = $clog2(NOut + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          loadValid,
    input  logic [CB-1:0]                 loadChannel,
    input  logic [MemoryElementWidth-1:0] loadData,
    output logic                          loadReady,
    input  logic                          reqValid,
    input  logic [1:0]                    reqOp,
    input  logic [CB-1:0]                 reqChannel,
    input  logic [MemoryElementWidth-1:0] reqData,
    output logic                          reqReady,
    output logic                          rspValid,
    output logic [MemoryElementWidth-1:0] rspData,
    output logic                          rspError,
    output logic                          drainValid,
    output logic [MemoryElementWidth-1:0] drainData,
    input  logic                          drainReady,
    output logic [OB-1:0]                 outCount
);
    localparam int W = MemoryElementWidth;

    typedef enum logic {IDLE, RESP} state_t;
    typedef struct packed {
        logic         err;
        logic [W-1:0] data;
    } rsp_t;

    state_t state, state_nx;
    rsp_t   rsp_q, rsp_nx;

    logic [NChannels-1:0]         ld_sel, rq_sel, ch_full, ch_push, ch_pop;
    logic [NChannels-1:0][W-1:0]  ch_head;
    logic [NChannels-1:0][NB-1:0] ch_count;
    logic [W-1:0]                 sel_head;
    logic [NB-1:0]                sel_cnt;
    logic                         accept, o_push, o_pop, o_full;
    logic [W-1:0]                 o_head;
    logic [OB-1:0]                o_count;

    // One-hot channel decode; an out-of-range channel simply matches nothing.
    always_comb begin
        ld_sel   = '0;
        rq_sel   = '0;
        sel_head = '0;
        sel_cnt  = '0;
        for (int c = 0; c < NChannels; c++) begin
            ld_sel[c] = (loadChannel == CB'(c));
            rq_sel[c] = (reqChannel == CB'(c));
            if (rq_sel[c]) begin
                sel_head = ch_head[c];
                sel_cnt  = ch_count[c];
            end
        end
    end

    assign ch_push   = {NChannels{loadValid}} & ld_sel & ~ch_full;
    assign loadReady = |(ld_sel & ~ch_full);

    for (genvar c = 0; c < NChannels; c++) begin : g_ch
        io_fifo #(.W(W), .N(NIn), .NB(NB)) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (ch_push[c]),
            .push_data (loadData),
            .pop       (ch_pop[c]),
            .head      (ch_head[c]),
            .count     (ch_count[c]),
            .full      (ch_full[c])
        );
    end

    assign reqReady = (state == IDLE);
    assign accept   = reqValid && reqReady;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rsp_q <= '0;
        end else begin
            state <= state_nx;
            rsp_q <= rsp_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rsp_nx   = '0;
        ch_pop   = '0;
        o_push   = 1'b0;
        case (state)
            IDLE:    if (reqValid) state_nx = RESP;
            default: state_nx = IDLE;
        endcase
        if (accept) begin
            case (reqOp)
                2'd0: begin
                    if (|rq_sel) rsp_nx.data = W'(sel_cnt);
                    else         rsp_nx.err  = 1'b1;
                end
                2'd1: begin
                    if ((|rq_sel) && (sel_cnt != '0)) begin
                        rsp_nx.data = sel_head;
                        ch_pop      = rq_sel;
                    end else begin
                        rsp_nx.err = 1'b1;
                    end
                end
                2'd2: begin
                    if (!o_full || OutOverwrite) o_push     = 1'b1;
                    else                         rsp_nx.err = 1'b1;
                end
                default: rsp_nx.err = 1'b1;
            endcase
        end
    end

    // An overwrite on a full FIFO shares the single read-pointer advance with a same-edge drain,
    // so full+push+drain loses exactly one (the oldest) entry and the count stays at NOut.
    assign o_pop = (drainValid && drainReady) || (o_push && o_full);

    io_fifo #(.W(W), .N(NOut), .NB(OB)) u_out (
        .clock     (clock),
        .reset     (reset),
        .push      (o_push),
        .push_data (reqData),
        .pop       (o_pop),
        .head      (o_head),
        .count     (o_count),
        .full      (o_full)
    );

    assign rspValid   = (state == RESP);
    assign rspData    = rsp_q.data;
    assign rspError   = rsp_q.err;
    assign drainValid = (o_count != '0);
    assign drainData  = o_head;
    assign outCount   = o_count;
endmodule

// File: tb/tb_io_channel_unit.sv
// Directed bench for io_channel_unit: a drop-mode and an overwrite-mode instance share stimulus.

module tb_io_channel_unit;
    localparam int W = 12, NIN = 16, NOUT = 16, NCH = 3, CB = 2, OB = 5;

    logic          clock = 1'b0, reset = 1'b1;
    logic          loadValid = 1'b0, reqValid = 1'b0, drainReady = 1'b0;
    logic [CB-1:0] loadChannel = '0, reqChannel = '0;
    logic [W-1:0]  loadData = '0, reqData = '0;
    logic [1:0]    reqOp = '0;

    logic          loadReady, reqReady, rspValid, rspError, drainValid;
    logic [W-1:0]  rspData, drainData;
    logic [OB-1:0] outCount;
    logic          loadReady_ow, reqReady_ow, rspValid_ow, rspError_ow, drainValid_ow;
    logic [W-1:0]  rspData_ow, drainData_ow;
    logic [OB-1:0] outCount_ow;

    int n_chk = 0, n_fail = 0;
    logic [W-1:0] q0[$], q1[$];

    always #5 clock = ~clock;

    io_channel_unit #(.MemoryElementWidth(W), .NIn(NIN), .NOut(NOUT), .NChannels(NCH),
                      .OutOverwrite(1'b0)) dut (
        .clock(clock), .reset(reset), .loadValid(loadValid), .loadChannel(loadChannel),
        .loadData(loadData), .loadReady(loadReady), .reqValid(reqValid), .reqOp(reqOp),
        .reqChannel(reqChannel), .reqData(reqData), .reqReady(reqReady), .rspValid(rspValid),
        .rspData(rspData), .rspError(rspError), .drainValid(drainValid), .drainData(drainData),
        .drainReady(drainReady), .outCount(outCount));

    io_channel_unit #(.MemoryElementWidth(W), .NIn(NIN), .NOut(NOUT), .NChannels(NCH),
                      .OutOverwrite(1'b1)) dut_ow (
        .clock(clock), .reset(reset), .loadValid(loadValid), .loadChannel(loadChannel),
        .loadData(loadData), .loadReady(loadReady_ow), .reqValid(reqValid), .reqOp(reqOp),
        .reqChannel(reqChannel), .reqData(reqData), .reqReady(reqReady_ow),
        .rspValid(rspValid_ow), .rspData(rspData_ow), .rspError(rspError_ow),
        .drainValid(drainValid_ow), .drainData(drainData_ow), .drainReady(drainReady),
        .outCount(outCount_ow));

    always @(posedge clock) begin
        if (drainValid && drainReady)       q0.push_back(drainData);
        if (drainValid_ow && drainReady)    q1.push_back(drainData_ow);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic load(input logic [CB-1:0] ch, input logic [W-1:0] d);
        loadValid = 1'b1; loadChannel = ch; loadData = d;
        tick();
        loadValid = 1'b0;
    endtask

    // One request; optional same-edge load on the request channel. Captures the response and
    // the output FIFO counts right after the accepting edge.
    task automatic req(input logic [1:0] op, input logic [CB-1:0] ch, input logic [W-1:0] d,
                       input bit ld, input logic [W-1:0] ldd,
                       output logic [W-1:0] rd, output logic re, output logic [W-1:0] rd_ow,
                       output logic re_ow, output logic [OB-1:0] oc, output logic [OB-1:0] oc_ow);
        chk("reqReady", reqReady, 1);
        chk("reqReady_ow", reqReady_ow, 1);
        reqValid = 1'b1; reqOp = op; reqChannel = ch; reqData = d;
        if (ld) begin loadValid = 1'b1; loadChannel = ch; loadData = ldd; end
        tick();
        reqValid = 1'b0; loadValid = 1'b0;
        chk("rspValid", rspValid, 1);
        chk("rspValid_ow", rspValid_ow, 1);
        rd = rspData; re = rspError; rd_ow = rspData_ow; re_ow = rspError_ow;
        oc = outCount; oc_ow = outCount_ow;
        tick();
        chk("rspValid_drop", rspValid, 0);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [CB-1:0] ch;
        logic [W-1:0]  d;
        logic [W-1:0]  ed;
        logic          ee;
    } vec_t;

    vec_t tv[15];

    initial begin
        logic [W-1:0]  rd, rd_ow;
        logic          re, re_ow;
        logic [OB-1:0] oc, oc_ow;

        tv[0]  = '{2'd0, 2'd0, 12'd0,  12'd2,  1'b0};
        tv[1]  = '{2'd1, 2'd0, 12'd0,  12'd88, 1'b0};
        tv[2]  = '{2'd0, 2'd0, 12'd0,  12'd1,  1'b0};
        tv[3]  = '{2'd1, 2'd0, 12'd0,  12'd44, 1'b0};
        tv[4]  = '{2'd0, 2'd0, 12'd0,  12'd0,  1'b0};
        tv[5]  = '{2'd2, 2'd0, 12'd88, 12'd0,  1'b0};
        tv[6]  = '{2'd2, 2'd0, 12'd44, 12'd0,  1'b0};
        tv[7]  = '{2'd2, 2'd0, 12'd2,  12'd0,  1'b0};
        tv[8]  = '{2'd2, 2'd0, 12'd1,  12'd0,  1'b0};
        tv[9]  = '{2'd2, 2'd0, 12'd0,  12'd0,  1'b0};
        tv[10] = '{2'd1, 2'd1, 12'd0,  12'd0,  1'b1};
        tv[11] = '{2'd1, 2'd3, 12'd0,  12'd0,  1'b1};
        tv[12] = '{2'd0, 2'd3, 12'd0,  12'd0,  1'b1};
        tv[13] = '{2'd3, 2'd0, 12'd0,  12'd0,  1'b1};
        tv[14] = '{2'd0, 2'd2, 12'd0,  12'd0,  1'b0};

        // Reset state
        tick(); tick();
        chk("rst_rspValid", rspValid, 0);
        chk("rst_reqReady", reqReady, 1);
        chk("rst_drainValid", drainValid, 0);
        chk("rst_outCount", outCount, 0);
        chk("rst_loadReady", loadReady, 1);
        reset = 1'b0;
        tick();

        // Loads, then table of inSize/in/out/error requests with the consumer draining
        load(2'd0, 12'd88);
        load(2'd0, 12'd44);
        drainReady = 1'b1;
        for (int i = 0; i < 15; i++) begin
            req(tv[i].op, tv[i].ch, tv[i].d, 1'b0, '0, rd, re, rd_ow, re_ow, oc, oc_ow);
            chk($sformatf("vec%0d_data", i), rd, tv[i].ed);
            chk($sformatf("vec%0d_err", i), re, tv[i].ee);
            chk($sformatf("vec%0d_data_ow", i), rd_ow, tv[i].ed);
            chk($sformatf("vec%0d_err_ow", i), re_ow, tv[i].ee);
        end
        repeat (3) tick();
        drainReady = 1'b0;
        chk("drain_n", q0.size(), 5);
        if (q0.size() == 5) begin
            chk("drain0", q0[0], 88); chk("drain1", q0[1], 44); chk("drain2", q0[2], 2);
            chk("drain3", q0[3], 1);  chk("drain4", q0[4], 0);
        end
        chk("outCount_empty", outCount, 0);

        // Out-of-range load channel, and in on empty channel with same-edge load
        loadChannel = 2'd3;
        #0 chk("loadReady_badch", loadReady, 0);
        req(2'd1, 2'd1, '0, 1'b1, 12'd5, rd, re, rd_ow, re_ow, oc, oc_ow);
        chk("in_empty_ld_data", rd, 0);
        chk("in_empty_ld_err", re, 1);
        req(2'd0, 2'd1, '0, 1'b0, '0, rd, re, rd_ow, re_ow, oc, oc_ow);
        chk("in_empty_ld_landed", rd, 1);

        // Output overflow in both modes
        q0.delete(); q1.delete();
        for (int i = 1; i <= NOUT + 1; i++) begin
            req(2'd2, 2'd0, W'(i), 1'b0, '0, rd, re, rd_ow, re_ow, oc, oc_ow);
            chk($sformatf("ovf%0d_err", i), re, (i == NOUT + 1) ? 1 : 0);
            chk($sformatf("ovf%0d_err_ow", i), re_ow, 0);
        end
        chk("ovf_count", outCount, NOUT);
        chk("ovf_count_ow", outCount_ow, NOUT);
        drainReady = 1'b1;
        repeat (NOUT + 2) tick();
        drainReady = 1'b0;
        chk("ovf_drain_n", q0.size(), NOUT);
        chk("ovf_drain_n_ow", q1.size(), NOUT);
        for (int k = 0; k < NOUT; k++) begin
            if (k < q0.size()) chk($sformatf("ovf_drain%0d", k), q0[k], k + 1);
            if (k < q1.size()) chk($sformatf("ovf_drain%0d_ow", k), q1[k], k + 2);
        end

        // Fill ch0 to full, then same-edge load+in
        loadValid = 1'b1; loadChannel = 2'd0;
        for (int i = 0; i < NIN; i++) begin
            loadData = W'(100 + i);
            tick();
        end
        chk("full_loadReady", loadReady, 0);
        chk("full_loadReady_ow", loadReady_ow, 0);
        loadValid = 1'b0;
        req(2'd0, 2'd0, '0, 1'b0, '0, rd, re, rd_ow, re_ow, oc, oc_ow);
        chk("full_count", rd, NIN);
        req(2'd1, 2'd0, '0, 1'b0, '0, rd, re, rd_ow, re_ow, oc, oc_ow);
        chk("full_pop", rd, 100);
        req(2'd1, 2'd0, '0, 1'b1, 12'd7, rd, re, rd_ow, re_ow, oc, oc_ow);
        chk("ldin_data", rd, 101);
        chk("ldin_err", re, 0);
        req(2'd0, 2'd0, '0, 1'b0, '0, rd, re, rd_ow, re_ow, oc, oc_ow);
        chk("ldin_count", rd, NIN - 1);
        load(2'd0, 12'd8);
        req(2'd0, 2'd0, '0, 1'b0, '0, rd, re, rd_ow, re_ow, oc, oc_ow);
        chk("refill_count", rd, NIN);
        for (int i = 0; i < NIN; i++) begin
            req(2'd1, 2'd0, '0, 1'b0, '0, rd, re, rd_ow, re_ow, oc, oc_ow);
            chk($sformatf("order%0d", i), rd, (i < NIN - 2) ? 102 + i : (i == NIN - 2 ? 7 : 8));
        end
        req(2'd0, 2'd0, '0, 1'b0, '0, rd, re, rd_ow, re_ow, oc, oc_ow);
        chk("ch0_empty", rd, 0);

        // Same-edge out+drain on a full output FIFO
        for (int i = 0; i < NOUT; i++)
            req(2'd2, 2'd0, W'(200 + i), 1'b0, '0, rd, re, rd_ow, re_ow, oc, oc_ow);
        chk("ofull_count", outCount, NOUT);
        drainReady = 1'b1;
        req(2'd2, 2'd0, 12'd250, 1'b0, '0, rd, re, rd_ow, re_ow, oc, oc_ow);
        drainReady = 1'b0;
        chk("odrain_err", re, 1);
        chk("odrain_count", oc, NOUT - 1);
        chk("odrain_err_ow", re_ow, 0);
        chk("odrain_count_ow", oc_ow, NOUT);

        // Reset while a response is pending and FIFOs hold data
        load(2'd0, 12'd9);
        reqValid = 1'b1; reqOp = 2'd0; reqChannel = 2'd0;
        tick();
        reqValid = 1'b0;
        chk("pend_rspValid", rspValid, 1);
        chk("pend_rspData", rspData, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_rspValid", rspValid, 0);
        chk("arst_rspData", rspData, 0);
        chk("arst_rspError", rspError, 0);
        chk("arst_drainValid", drainValid, 0);
        chk("arst_drainValid_ow", drainValid_ow, 0);
        chk("arst_outCount", outCount, 0);
        chk("arst_reqReady", reqReady, 1);
        @(negedge clock);
        reset = 1'b0;
        tick();
        req(2'd0, 2'd0, '0, 1'b0, '0, rd, re, rd_ow, re_ow, oc, oc_ow);
        chk("post_rst_count", rd, 0);
        chk("post_rst_err", re, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
